// File: rtl/scan_sel_gen_pkg.sv
// Shared encodings and constants for the channel-scan select generator.
package scan_sel_gen_pkg;
  localparam int NUM_CH = 8;
  localparam logic [2:0] LAST_CH = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEEK  = 2'd1,
    ST_DWELL = 2'd2
  } state_e;
endpackage

// File: rtl/scan_sel_gen.sv
// Walks enabled channels 0..7, holding each {A,B,C} selection for a dwell
// time with a break-before-make gap; one-shot or continuous frames.
module scan_sel_gen
  import scan_sel_gen_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               sel_valid,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  localparam logic [DWELL_W-1:0] DW_ONE = DWELL_W'(1);

  state_e              state_q, state_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [2:0]          abc_q, abc_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [DWELL_W-1:0]  ld_q, ld_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic                mode_q, mode_d;
  logic                sel_q, sel_d;
  logic                done_q, done_d;
  logic                wrap_q, wrap_d;
  logic                eof;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    abc_d   = abc_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    eof     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          mask_d = ch_mask;
          mode_d = mode_cont;
          // Counter reload holds D-1, with a zero dwell treated as one cycle.
          ld_d   = (dwell == '0) ? '0 : dwell - DW_ONE;
          ptr_d  = 3'd0;
          if (ch_mask == '0) done_d  = 1'b1;
          else               state_d = ST_SEEK;
        end
      end
      ST_SEEK: begin
        if (stop) begin
          state_d = ST_IDLE;
          sel_d   = 1'b0;
        end else if (mask_q[ptr_q]) begin
          abc_d   = ptr_q;
          sel_d   = 1'b1;
          cnt_d   = ld_q;
          state_d = ST_DWELL;
        end else if (ptr_q != LAST_CH) begin
          ptr_d = ptr_q + 3'd1;
        end else begin
          eof = 1'b1;
        end
      end
      ST_DWELL: begin
        if (stop) begin
          state_d = ST_IDLE;
          sel_d   = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DW_ONE;
        end else begin
          sel_d = 1'b0;
          if (ptr_q != LAST_CH) begin
            ptr_d   = ptr_q + 3'd1;
            state_d = ST_SEEK;
          end else begin
            eof = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 1'b0;
      end
    endcase

    if (eof) begin
      if (mode_q) begin
        ptr_d   = 3'd0;
        wrap_d  = 1'b1;
        state_d = ST_SEEK;
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd0;
      abc_q   <= 3'd0;
      cnt_q   <= '0;
      ld_q    <= '0;
      mask_q  <= '0;
      mode_q  <= 1'b0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      abc_q   <= abc_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign A         = abc_q[2];
  assign B         = abc_q[1];
  assign C         = abc_q[0];
  assign sel_valid = sel_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed bench for scan_sel_gen: frame schedules, skip timing, stop, reset.
module tb_scan_sel_gen;
  logic       clk, rst_n;
  logic       start, stop, mode_cont;
  logic [7:0] ch_mask;
  logic [7:0] dwell;
  logic       A, B, C, sel_valid, busy, done, wrap;

  int checks = 0;
  int errors = 0;

  scan_sel_gen #(.DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .mode_cont(mode_cont), .ch_mask(ch_mask), .dwell(dwell),
    .A(A), .B(B), .C(C), .sel_valid(sel_valid), .busy(busy),
    .done(done), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] m, input logic [7:0] d, input logic cont);
    ch_mask = m; dwell = d; mode_cont = cont; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
    ch_mask = '0; dwell = '0;
    #12;
    chk("rst_abc",  {29'd0, A, B, C}, 32'd0);
    chk("rst_sel",  sel_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wrap", wrap, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // Full mask, dwell 3, one-shot: period 4 per channel, done 32 cycles after start.
    go(8'hFF, 8'd3, 1'b0);
    chk("ff_busy0", busy, 1'b1);
    chk("ff_sel0",  sel_valid, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("ff_sel",  sel_valid, (k <= 31) && (((k - 1) % 4) < 3));
      chk("ff_done", done, k == 32);
      chk("ff_busy", busy, k < 32);
      if (sel_valid) chk("ff_abc", {29'd0, A, B, C}, (k - 1) / 4);
    end
    step();
    chk("ff_done_once", done, 1'b0);

    // Sparse mask 1000_0100, dwell 0: ch2 at cycle 3, ch7 at cycle 9, done at 10.
    go(8'b1000_0100, 8'd0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("sp_sel",  sel_valid, (k == 3) || (k == 9));
      chk("sp_done", done, k == 10);
      chk("sp_busy", busy, k < 10);
      if (k == 3) chk("sp_abc2", {29'd0, A, B, C}, 32'd2);
      if (k == 9) chk("sp_abc7", {29'd0, A, B, C}, 32'd7);
    end

    // Empty mask: done only, never busy.
    go(8'h00, 8'd4, 1'b0);
    chk("em_done", done, 1'b1);
    chk("em_busy", busy, 1'b0);
    chk("em_sel",  sel_valid, 1'b0);
    step();
    chk("em_done_off", done, 1'b0);
    chk("em_busy_off", busy, 1'b0);

    // Continuous 8'h81, dwell 2: 12-cycle frame, wrap at each frame end.
    go(8'h81, 8'd2, 1'b1);
    for (int k = 1; k <= 25; k++) begin
      step();
      chk("ct_sel",  sel_valid, (((k - 1) % 12) < 2) || ((((k - 1) % 12) >= 9) && (((k - 1) % 12) <= 10)));
      chk("ct_wrap", wrap, (k % 12) == 0);
      chk("ct_done", done, 1'b0);
      if (sel_valid) chk("ct_abc", {29'd0, A, B, C}, (((k - 1) % 12) < 2) ? 32'd0 : 32'd7);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("ct_stop_busy", busy, 1'b0);
    chk("ct_stop_wrap", wrap, 1'b0);

    // Stop in 2nd cycle of ch5 dwell (dwell 4, ch5 selected at cycle 26).
    go(8'hFF, 8'd4, 1'b0);
    for (int k = 1; k <= 27; k++) begin
      if (k == 10) begin start = 1'b1; ch_mask = 8'h00; end
      step();
      start = 1'b0;
      if (k == 10) begin
        chk("ign_busy", busy, 1'b1);
        chk("ign_done", done, 1'b0);
      end
    end
    chk("sp5_sel", sel_valid, 1'b1);
    chk("sp5_abc", {29'd0, A, B, C}, 32'd5);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", busy, 1'b0);
    chk("stop_sel",  sel_valid, 1'b0);
    chk("stop_abc",  {29'd0, A, B, C}, 32'd5);
    chk("stop_done", done, 1'b0);
    step();
    chk("stop_done2", done, 1'b0);
    chk("stop_abc2",  {29'd0, A, B, C}, 32'd5);

    // Reset mid-dwell on ch3, then restart from ch0.
    go(8'h08, 8'd5, 1'b0);
    for (int k = 1; k <= 5; k++) step();
    chk("pre_rst_abc", {29'd0, A, B, C}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_abc",  {29'd0, A, B, C}, 32'd0);
    chk("arst_sel",  sel_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", busy, 1'b0);
    go(8'hFF, 8'd1, 1'b0);
    step();
    chk("rs_sel", sel_valid, 1'b1);
    chk("rs_abc", {29'd0, A, B, C}, 32'd0);
    step();
    chk("rs_gap", sel_valid, 1'b0);
    step();
    chk("rs_abc1", {29'd0, A, B, C}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
